// File: rtl/conv_model.sv
// conv_model: streaming 3x3 convolution with 2 uint8 input channels and 4 int8-quantised
// output channels. Valid padding, stride 1. Results are requantised and queued in a
// first-word fall-through FIFO.
//
// Optional feature macro: CONV_RELU_EN
//   defined   -> ReLU with unsigned saturation to [0,255]
//   undefined -> signed saturation to [-128,127] (two's complement bytes)
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   i_data[15:0]   pixel, channel c in bits [8c+7:8c]
//   i_valid        pixel accepted this cycle (no backpressure)
//   weight_wr_*    weight write port (0..71 kernels, 72..75 biases, 76 coeff)
//   o_data[31:0]   FIFO head, output channel k in bits [8k+7:8k]
//   o_valid        FIFO not empty
//   fifo_rd_en     pop the FIFO head when o_valid is high
module conv_model #(
    parameter int unsigned IMG_W      = 5,
    parameter int unsigned IMG_H      = 5,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_data,
    input  logic        i_valid,
    input  logic [15:0] weight_wr_data,
    input  logic [31:0] weight_wr_addr,
    input  logic        weight_wr_en,
    output logic [31:0] o_data,
    output logic        o_valid,
    input  logic        fifo_rd_en
);

    localparam int unsigned CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = AW + 1;

    // Weight storage
    logic signed [7:0]  w_q    [72];
    logic signed [15:0] bias_q [4];
    logic        [15:0] coeff_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 72; i++) w_q[i] <= '0;
            for (int i = 0; i < 4; i++) bias_q[i] <= '0;
            coeff_q <= 16'h0100;
        end else if (weight_wr_en) begin
            if (weight_wr_addr < 32'd72) begin
                w_q[weight_wr_addr[6:0]] <= weight_wr_data[7:0];
            end else if (weight_wr_addr < 32'd76) begin
                bias_q[weight_wr_addr[1:0]] <= weight_wr_data;
            end else if (weight_wr_addr == 32'd76) begin
                coeff_q <= weight_wr_data;
            end
        end
    end

    // Position counters, line buffers and window
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [15:0]   lb0_q [IMG_W];  // previous row
    logic [15:0]   lb1_q [IMG_W];  // two rows back
    logic [15:0]   win_q [3][3];   // [ky][kx], ky=2 is the current row
    logic [15:0]   win_d [3][3];
    logic          win_valid;

    assign win_valid = (row_q >= RW'(2)) && (col_q >= CW'(2));

    // Window as it stands once the incoming pixel's column is shifted in
    always_comb begin
        for (int ky = 0; ky < 3; ky++) begin
            win_d[ky][0] = win_q[ky][1];
            win_d[ky][1] = win_q[ky][2];
        end
        win_d[0][2] = lb1_q[col_q];
        win_d[1][2] = lb0_q[col_q];
        win_d[2][2] = i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
            for (int i = 0; i < int'(IMG_W); i++) begin
                lb0_q[i] <= '0;
                lb1_q[i] <= '0;
            end
            for (int ky = 0; ky < 3; ky++) begin
                for (int kx = 0; kx < 3; kx++) win_q[ky][kx] <= '0;
            end
        end else if (i_valid) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= i_data;
            win_q        <= win_d;
            if (col_q == CW'(IMG_W - 1)) begin
                col_q <= '0;
                row_q <= (row_q == RW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // Stage 1: MAC over the updated window
    logic signed [23:0] acc_d [4];
    logic signed [23:0] acc_q [4];
    logic               acc_vld_q;

    always_comb begin
        logic signed [23:0] px_ext;
        logic signed [23:0] w_ext;
        for (int oc = 0; oc < 4; oc++) begin
            acc_d[oc] = {{8{bias_q[oc][15]}}, bias_q[oc]};
            for (int ic = 0; ic < 2; ic++) begin
                for (int ky = 0; ky < 3; ky++) begin
                    for (int kx = 0; kx < 3; kx++) begin
                        px_ext = $signed({16'b0, win_d[ky][kx][8*ic +: 8]});
                        w_ext  = {{16{w_q[oc*18 + ic*9 + ky*3 + kx][7]}},
                                  w_q[oc*18 + ic*9 + ky*3 + kx]};
                        acc_d[oc] = acc_d[oc] + px_ext * w_ext;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_vld_q <= 1'b0;
            for (int oc = 0; oc < 4; oc++) acc_q[oc] <= '0;
        end else begin
            acc_vld_q <= i_valid && win_valid;
            if (i_valid) acc_q <= acc_d;
        end
    end

    // Stage 2: requantise and saturate; the result goes straight into the FIFO
    logic [31:0] res_word;

    always_comb begin
        logic signed [40:0] prod;
        logic signed [32:0] res;
        res_word = '0;
        for (int oc = 0; oc < 4; oc++) begin
            prod = $signed({{17{acc_q[oc][23]}}, acc_q[oc]}) * $signed({25'b0, coeff_q});
            res  = prod[40:8];  // arithmetic >>> 8, rounds toward -inf
`ifdef CONV_RELU_EN
            if (res < 33'sd0) begin
                res_word[8*oc +: 8] = 8'h00;
            end else if (res > 33'sd255) begin
                res_word[8*oc +: 8] = 8'hFF;
            end else begin
                res_word[8*oc +: 8] = res[7:0];
            end
`else
            if (res < -33'sd128) begin
                res_word[8*oc +: 8] = 8'h80;
            end else if (res > 33'sd127) begin
                res_word[8*oc +: 8] = 8'h7F;
            end else begin
                res_word[8*oc +: 8] = res[7:0];
            end
`endif
        end
    end

    // Output FIFO, first-word fall-through
    logic [31:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic           pop;
    logic           push_ok;

    assign pop     = fifo_rd_en && (count_q != '0);
    // A full FIFO drops new results unless a pop frees a slot in the same cycle
    assign push_ok = acc_vld_q && ((count_q != CNT_W'(FIFO_DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= res_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign o_valid = (count_q != '0);
    assign o_data  = o_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_conv_model.sv
module tb_conv_model;

    localparam int IMG_W = 5;
    localparam int IMG_H = 5;
    localparam int NPIX  = IMG_W * IMG_H;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] i_data;
    logic        i_valid;
    logic [15:0] weight_wr_data;
    logic [31:0] weight_wr_addr;
    logic        weight_wr_en;
    logic [31:0] o_data, o_data4;
    logic        o_valid, o_valid4;
    logic        fifo_rd_en, rd_en4;

    conv_model #(.IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
        .weight_wr_data(weight_wr_data), .weight_wr_addr(weight_wr_addr),
        .weight_wr_en(weight_wr_en), .o_data(o_data), .o_valid(o_valid),
        .fifo_rd_en(fifo_rd_en)
    );

    conv_model #(.IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
        .weight_wr_data(weight_wr_data), .weight_wr_addr(weight_wr_addr),
        .weight_wr_en(weight_wr_en), .o_data(o_data4), .o_valid(o_valid4),
        .fifo_rd_en(rd_en4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model state
    int          m_w [72];
    int          m_bias [4];
    int          m_coeff;
    int          frame [NPIX];
    int          pix_idx;
    logic [31:0] exp_q [$];
    logic [31:0] exp4_q [$];

    task automatic model_reset();
        for (int i = 0; i < 72; i++) m_w[i] = 0;
        for (int i = 0; i < 4; i++) m_bias[i] = 0;
        m_coeff = 256;
        pix_idx = 0;
        exp_q.delete();
        exp4_q.delete();
    endtask

    function automatic logic [31:0] expect_win(input int r, input int c);
        logic [31:0] out;
        longint acc, prod, res;
        int p;
        out = '0;
        for (int oc = 0; oc < 4; oc++) begin
            acc = m_bias[oc];
            for (int ic = 0; ic < 2; ic++)
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++) begin
                        p = (frame[(r - 2 + ky) * IMG_W + (c - 2 + kx)] >> (8 * ic)) & 255;
                        acc += longint'(p) * m_w[oc * 18 + ic * 9 + ky * 3 + kx];
                    end
            prod = acc * m_coeff;
            res  = prod >>> 8;
`ifdef CONV_RELU_EN
            if (res < 0) res = 0;
            else if (res > 255) res = 255;
`else
            if (res < -128) res = -128;
            else if (res > 127) res = 127;
`endif
            out[8 * oc +: 8] = res[7:0];
        end
        return out;
    endfunction

    task automatic wr(input logic [31:0] addr, input int data);
        logic [7:0]  b;
        logic [15:0] h;
        b = data[7:0];
        h = data[15:0];
        weight_wr_addr = addr;
        weight_wr_data = h;
        weight_wr_en   = 1'b1;
        @(posedge clk); #1;
        weight_wr_en = 1'b0;
        if (addr < 72) m_w[addr] = int'($signed(b));
        else if (addr < 76) m_bias[addr - 72] = int'($signed(h));
        else if (addr == 76) m_coeff = int'(h);
    endtask

    task automatic send_pixel(input logic [15:0] d, input bit gaps, input bit lat_chk);
        int r, c;
        logic [31:0] e;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        r = pix_idx / IMG_W;
        c = pix_idx % IMG_W;
        frame[pix_idx] = int'(d);
        if (r >= 2 && c >= 2) begin
            e = expect_win(r, c);
            if (exp_q.size() < 16) exp_q.push_back(e);
            if (exp4_q.size() < 4) exp4_q.push_back(e);
        end
        i_data  = d;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        if (lat_chk && pix_idx == 12) begin
            check("lat_plus1", o_valid, 0);
            @(posedge clk); #1;
            check("lat_plus2", o_valid, 1);
        end
        pix_idx = (pix_idx == NPIX - 1) ? 0 : pix_idx + 1;
    endtask

    task automatic send_frame(input logic [15:0] d, input bit rnd, input bit gaps, input bit lat);
        for (int i = 0; i < NPIX; i++) send_pixel(rnd ? 16'($urandom) : d, gaps, lat);
    endtask

    task automatic drain(input string tag);
        logic [31:0] e;
        repeat (3) begin @(posedge clk); #1; end
        fifo_rd_en = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, o_valid, 1);
            check({tag, "_data"}, o_data, e);
            @(posedge clk); #1;
        end
        fifo_rd_en = 1'b0;
        check({tag, "_empty"}, o_valid, 0);
    endtask

    task automatic drain4(input string tag);
        logic [31:0] e;
        rd_en4 = 1'b1;
        while (exp4_q.size() > 0) begin
            e = exp4_q.pop_front();
            check({tag, "_valid"}, o_valid4, 1);
            check({tag, "_data"}, o_data4, e);
            @(posedge clk); #1;
        end
        rd_en4 = 1'b0;
        check({tag, "_empty"}, o_valid4, 0);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        #2;
        check("rst_valid", o_valid, 0);
        check("rst_valid4", o_valid4, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic rand_weights();
        for (int a = 0; a < 72; a++) wr(a, $urandom_range(0, 15) - 8);
        for (int a = 72; a < 76; a++) wr(a, $urandom_range(0, 2000) - 1000);
        wr(76, $urandom_range(0, 16));
    endtask

    initial begin
        rst_n = 1'b0;
        i_data = '0;
        i_valid = 1'b0;
        weight_wr_data = '0;
        weight_wr_addr = '0;
        weight_wr_en = 1'b0;
        fifo_rd_en = 1'b0;
        rd_en4 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", o_valid, 0);
        check("reset_data", o_data, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Unity coeff left at its reset value; saturating sums
        for (int a = 0; a < 72; a++) wr(a, 1);
        for (int a = 72; a < 76; a++) wr(a, 10);
        send_frame(16'h0064, 1'b0, 1'b0, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
`ifdef CONV_RELU_EN
        check("sat_const", o_data, 32'hFFFF_FFFF);
`else
        check("sat_const", o_data, 32'h7F7F_7F7F);
`endif
        drain("sat");

        // Small coeff truncates to zero, then a large bias on channel 2
        wr(76, 16'h0004);
        send_frame(16'h0101, 1'b0, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        check("trunc_const", o_data, 32'h0000_0000);
        drain("trunc");
        wr(74, 1024);
        send_frame(16'h0101, 1'b0, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        check("bias2_const", o_data, 32'h0010_0000);
        drain("bias2");

        // Negative kernels
        for (int a = 0; a < 72; a++) wr(a, 8'hFF);
        for (int a = 72; a < 76; a++) wr(a, 0);
        wr(76, 16'h0100);
        send_frame(16'h0A0A, 1'b0, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
`ifdef CONV_RELU_EN
        check("neg_const", o_data, 32'h0000_0000);
`else
        check("neg_const", o_data, 32'h8080_8080);
`endif
        drain("neg");

        // Pop while empty must not disturb the FIFO
        fifo_rd_en = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        fifo_rd_en = 1'b0;
        check("empty_pop_valid", o_valid, 0);
        check("empty_pop_data", o_data, 0);
        send_frame(16'h0, 1'b1, 1'b1, 1'b0);
        drain("after_empty_pop");

        // Randomised frames, with ignored out-of-map writes mixed in
        for (int it = 0; it < 4; it++) begin
            rand_weights();
            wr(77, 16'h7FFF);
            wr(32'hFFFF_FFB4, 16'h1234);
            send_frame(16'h0, 1'b1, (it % 2) == 1, 1'b0);
            drain("rand");
        end

        // Overflow: 18 results into 16- and 4-deep FIFOs with no reads
        reset_dut();
        rand_weights();
        send_frame(16'h0, 1'b1, 1'b1, 1'b0);
        send_frame(16'h0, 1'b1, 1'b0, 1'b0);
        drain("ovf16");
        drain4("ovf4");

        // Mid-frame asynchronous reset with a loaded FIFO
        rand_weights();
        send_frame(16'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) send_pixel(16'($urandom), 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        check("pre_rst_valid", o_valid, 1);
        reset_dut();
        // Only kernels rewritten: biases and coeff must be at reset values
        for (int a = 0; a < 72; a++) wr(a, $urandom_range(0, 3));
        send_frame(16'h0, 1'b1, 1'b0, 1'b0);
        drain("post_rst");
        drain4("post_rst4");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
